// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, the NOP encoding and the fetch-state encoding.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0;

    typedef enum logic {
        IDLE,
        WAIT
    } fetch_state_e;
endpackage

// File: rtl/imem_fetch_responder_array.sv
// Instruction word store: one synchronous write port, one asynchronous read port. Contents are not reset.
import cpu_pkg::*;

module imem_array #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [XLEN-1:0]   rdata_o
);
    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: single-entry tag, fixed fetch latency, stall back to the PC.
// Optional IMEM_PERF_CNT_EN adds fetch and stall-cycle counters.
import cpu_pkg::*;

module imem_fetch_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [XLEN-1:0]   addr_i,
    output logic [XLEN-1:0]   instr_o,
    output logic              stall_o,
    output logic              err_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i
`ifdef IMEM_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       stall_cnt_o
`endif
);
    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] tag_q, tag_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            tag_valid_q, tag_valid_d;
    logic            err_q, err_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rdata;
    logic            hit, illegal, capture;

    imem_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
        .clk_i   (clk_i),
        .we_i    (we_i),
        .waddr_i (waddr_i),
        .wdata_i (wdata_i),
        .raddr_i (req_addr_q[ADDR_W+1:2]),
        .rdata_o (rdata)
    );

    assign hit     = tag_valid_q && (addr_i == tag_q);
    assign illegal = (req_addr_q[1:0] != 2'b00) || (req_addr_q >= 32'(4 * DEPTH));
    assign stall_o = start_i && ((state_q == WAIT) || !hit);
    assign instr_o = instr_q;
    assign err_o   = err_q;

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        req_addr_d  = req_addr_q;
        instr_d     = instr_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !hit) begin
                    req_addr_d = addr_i;
                    cnt_d      = 4'(LATENCY - 1);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    capture     = 1'b1;
                    instr_d     = illegal ? NOP_INSTR : rdata;
                    err_d       = illegal;
                    tag_d       = req_addr_q;
                    tag_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
        endcase
        // Compare against the post-edge tag so a write racing a capture still invalidates it.
        if (we_i && (waddr_i == tag_d[ADDR_W+1:2])) tag_valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            req_addr_q  <= '0;
            instr_q     <= NOP_INSTR;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            req_addr_q  <= req_addr_d;
            instr_q     <= instr_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef IMEM_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (capture) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_o) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif
endmodule
